multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multicycle MIPS control unit: a Moore FSM that sequences one instruction over 3–5 cycles on a shared instruction/data memory port.
- Extends the single-cycle opcode/ALU decode with ADDI and J, memory wait-state handshake, an illegal-instruction trap mode and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath (PC, IR, register file, ALU, memory port).

Parameters:
- OP_WIDTH_P, 6, opcode width; must be ≥6, decode uses bits [5:0].
- FUNCT_WIDTH_P, 6, funct width; must be ≥6, decode uses bits [5:0].
- ALU_CNTRL_WIDTH_P, 3, ALU control width; must be ≥3, codes zero-extended.
- CNT_WIDTH_P, 32, width of the retired-instruction counter.
- TRAP_EN_P, 1, 1: an illegal instruction enters TRAP; 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_opcode  in  OP_WIDTH_P  opcode from IR, valid from DECODE onward.
- i_function  in  FUNCT_WIDTH_P  funct field from IR.
- i_zero  in  1  ALU zero flag.
- i_mem_ready  in  1  memory access completes this cycle.
- o_iord  out  1  memory address select: 0=PC, 1=ALUOut.
- o_mem_wr_en  out  1  memory write.
- o_ir_wr_en  out  1  IR load.
- o_pc_wr_en  out  1  PC load, includes the taken-branch term.
- o_pc_src_sel  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- o_alu_src_a_sel  out  1  ALU A input: 0=PC, 1=rs.
- o_alu_src_b_sel  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- o_alu_cntrl  out  ALU_CNTRL_WIDTH_P  ALU operation.
- o_reg_wr_en  out  1  register file write.
- o_reg_wr_addr_sel  out  1  register write address: 0=rt, 1=rd.
- o_reg_wr_data_sel  out  1  register write data: 0=ALUOut, 1=memory data.
- o_trap  out  1  sticky illegal-instruction flag.
- o_retired  out  CNT_WIDTH_P  count of retired instructions.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct is illegal.
- Opcode and funct are latched in DECODE; later states use only the latched copy.
- Outputs are decoded from the state register (and the latched funct). Every output not listed for a state is 0; o_alu_cntrl defaults to add.
- While i_rst_n=0: all enables are 0; on the clock edge state becomes FETCH, o_retired becomes 0 and o_trap becomes 0. Reset asserted mid-instruction aborts it with no write.
- FETCH: iord=0, src_a=0, src_b=01, add, pc_src=00. ir_wr_en and pc_wr_en equal i_mem_ready. Hold in FETCH until ready, then go to DECODE.
- DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next state:
  - LW/SW: MEMADR.
  - RTYPE with legal funct: EXECUTE.
  - BEQ: BRANCH.
  - ADDI: ADDIEXEC.
  - J: JUMP.
  - Anything else: TRAP if TRAP_EN_P=1, else FETCH with no retire.
- MEMADR: src_a=1, src_b=10, add. Next state MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: iord=1. Hold until ready, then MEMWB.
- MEMWB: reg_wr_en=1, addr_sel=0, data_sel=1. Next state FETCH.
- MEMWRITE: iord=1, mem_wr_en=1 every cycle in the state. Hold until ready, then FETCH.
- EXECUTE: src_a=1, src_b=00, alu_cntrl from funct. Next state ALUWB.
- ALUWB: reg_wr_en=1, addr_sel=1, data_sel=0. Next state FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_wr_en=i_zero. Next state FETCH.
- ADDIEXEC: src_a=1, src_b=10, add. Next state ADDIWB.
- ADDIWB: reg_wr_en=1, addr_sel=0, data_sel=0. Next state FETCH.
- JUMP: pc_src=10, pc_wr_en=1. Next state FETCH.
- TRAP: o_trap=1, all enables 0. Exit only by reset.
- Zero-wait latency in cycles: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- o_retired increments by 1 on the edge leaving MEMWB, MEMWRITE (with ready), ALUWB, BRANCH (taken or not), ADDIWB or JUMP. It wraps modulo 2^CNT_WIDTH_P.
- i_mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset, then RTYPE funct 100010 with ready held 1 → FETCH, DECODE, EXECUTE (alu_cntrl=110), ALUWB (reg_wr_en=1, addr_sel=1); o_retired=1 after 4 cycles.
- LW with ready low for 2 cycles in MEMREAD → 7 cycles total; MEMWB asserts reg_wr_en=1, data_sel=1; iord=1 throughout MEMREAD.
- BEQ with i_zero=1, then BEQ with i_zero=0 → pc_wr_en=1 in BRANCH for the first only; o_retired=2 after both.
- Opcode 111111 with TRAP_EN_P=1 → o_trap=1 from the cycle after DECODE and stays set; all enables 0 for 10 more cycles. Same opcode with TRAP_EN_P=0 → back to FETCH with o_retired unchanged.
- SW with reset asserted in the MEMWRITE cycle → mem_wr_en=0 that cycle, then FETCH, o_retired=0.
- CNT_WIDTH_P=4, run 16 J instructions → o_retired wraps to 0; every instruction is 3 cycles with pc_src=10 in JUMP.

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Moore-FSM control unit for a multicycle MIPS datapath. Sequences
//            one instruction over 3-5 cycles on a shared instruction/data
//            memory port, with memory wait states, an illegal-instruction
//            trap mode and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int OP_WIDTH_P        = 6,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3,
  parameter int CNT_WIDTH_P       = 32,
  parameter int TRAP_EN_P         = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [OP_WIDTH_P-1:0]        i_opcode,
  input  logic [FUNCT_WIDTH_P-1:0]     i_function,
  input  logic                         i_zero,
  input  logic                         i_mem_ready,
  output logic                         o_iord,
  output logic                         o_mem_wr_en,
  output logic                         o_ir_wr_en,
  output logic                         o_pc_wr_en,
  output logic [1:0]                   o_pc_src_sel,
  output logic                         o_alu_src_a_sel,
  output logic [1:0]                   o_alu_src_b_sel,
  output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
  output logic                         o_reg_wr_en,
  output logic                         o_reg_wr_addr_sel,
  output logic                         o_reg_wr_data_sel,
  output logic                         o_trap,
  output logic [CNT_WIDTH_P-1:0]       o_retired
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes (3-bit core, zero-extended to the port width)
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [3:0]             state_q,   state_d;
  logic [5:0]             op_q,      op_d;
  logic [5:0]             funct_q,   funct_d;
  logic                   trap_q,    trap_d;
  logic [CNT_WIDTH_P-1:0] retired_q, retired_d;

  // Only the low six bits of the IR fields take part in decode
  logic [5:0] op_w;
  logic [5:0] funct_w;
  assign op_w    = i_opcode[5:0];
  assign funct_w = i_function[5:0];

  // Funct-to-ALU mapping for legal R-type instructions
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic: instruction sequencing and memory handshake
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((op_w == OP_LW) || (op_w == OP_SW))             state_d = S_MEMADR;
        else if ((op_w == OP_RTYPE) && funct_legal(funct_w)) state_d = S_EXECUTE;
        else if (op_w == OP_BEQ)                            state_d = S_BRANCH;
        else if (op_w == OP_ADDI)                           state_d = S_ADDIEXEC;
        else if (op_w == OP_J)                              state_d = S_JUMP;
        else if (TRAP_EN_P != 0)                            state_d = S_TRAP;
        else                                                state_d = S_FETCH;
      end
      S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (i_mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Capture the IR fields in DECODE; the trap flag is sticky once TRAP is entered
  always_comb begin
    op_d    = op_q;
    funct_d = funct_q;
    if (state_q == S_DECODE) begin
      op_d    = op_w;
      funct_d = funct_w;
    end
    trap_d = trap_q | (state_d == S_TRAP);
  end

  // Count an instruction on the edge that leaves its final state
  always_comb begin
    retired_d = retired_q;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
        retired_d = retired_q + CNT_WIDTH_P'(1);
      S_MEMWRITE:
        if (i_mem_ready) retired_d = retired_q + CNT_WIDTH_P'(1);
      default: retired_d = retired_q;
    endcase
  end

  // State, latched fields, trap flag and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  // --------------------------------------------------------------------------
  // Moore output decode (enables are forced low while reset is asserted)
  // --------------------------------------------------------------------------
  logic       iord_w;
  logic       mem_wr_w;
  logic       ir_wr_w;
  logic       pc_wr_w;
  logic [1:0] pc_src_w;
  logic       src_a_w;
  logic [1:0] src_b_w;
  logic [2:0] alu_w;
  logic       reg_wr_w;
  logic       addr_sel_w;
  logic       data_sel_w;

  // Per-state datapath control; anything not named for a state stays 0 / add
  always_comb begin
    iord_w     = 1'b0;
    mem_wr_w   = 1'b0;
    ir_wr_w    = 1'b0;
    pc_wr_w    = 1'b0;
    pc_src_w   = 2'b00;
    src_a_w    = 1'b0;
    src_b_w    = 2'b00;
    alu_w      = ALU_ADD;
    reg_wr_w   = 1'b0;
    addr_sel_w = 1'b0;
    data_sel_w = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b_w = 2'b01;
        ir_wr_w = i_mem_ready;
        pc_wr_w = i_mem_ready;
      end
      S_DECODE: begin
        src_b_w = 2'b11;
      end
      S_MEMADR, S_ADDIEXEC: begin
        src_a_w = 1'b1;
        src_b_w = 2'b10;
      end
      S_MEMREAD: begin
        iord_w = 1'b1;
      end
      S_MEMWB: begin
        reg_wr_w   = 1'b1;
        data_sel_w = 1'b1;
      end
      S_MEMWRITE: begin
        iord_w   = 1'b1;
        mem_wr_w = 1'b1;
      end
      S_EXECUTE: begin
        src_a_w = 1'b1;
        alu_w   = funct_to_alu(funct_q);
      end
      S_ALUWB: begin
        reg_wr_w   = 1'b1;
        addr_sel_w = 1'b1;
      end
      S_BRANCH: begin
        src_a_w  = 1'b1;
        alu_w    = ALU_SUB;
        pc_src_w = 2'b01;
        pc_wr_w  = i_zero;
      end
      S_ADDIWB: begin
        reg_wr_w = 1'b1;
      end
      S_JUMP: begin
        pc_src_w = 2'b10;
        pc_wr_w  = 1'b1;
      end
      default: begin
        alu_w = ALU_ADD;
      end
    endcase
  end

  assign o_iord            = iord_w;
  assign o_mem_wr_en       = mem_wr_w & i_rst_n;
  assign o_ir_wr_en        = ir_wr_w  & i_rst_n;
  assign o_pc_wr_en        = pc_wr_w  & i_rst_n;
  assign o_reg_wr_en       = reg_wr_w & i_rst_n;
  assign o_pc_src_sel      = pc_src_w;
  assign o_alu_src_a_sel   = src_a_w;
  assign o_alu_src_b_sel   = src_b_w;
  assign o_reg_wr_addr_sel = addr_sel_w;
  assign o_reg_wr_data_sel = data_sel_w;
  assign o_trap            = trap_q;
  assign o_retired         = retired_q;

  // Zero-extend the 3-bit ALU code to the configured port width
  generate
    if (ALU_CNTRL_WIDTH_P > 3) begin : g_alu_wide
      assign o_alu_cntrl = {{(ALU_CNTRL_WIDTH_P-3){1'b0}}, alu_w};
    end else begin : g_alu_narrow
      assign o_alu_cntrl = alu_w;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Self-checking bench. Two instances share stimulus: A traps on
//            illegal opcodes with a 32-bit counter, B treats them as NOPs with
//            a 4-bit counter. An instruction-level model builds the expected
//            per-cycle outputs; a negedge process compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       iord;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       reg_wr;
    logic       addr_sel;
    logic       data_sel;
    logic       trap;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ready;

  always #5 clk = ~clk;

  logic       a_iord, a_mem_wr, a_ir_wr, a_pc_wr, a_src_a, a_reg_wr, a_addr, a_data, a_trap;
  logic [1:0] a_pc_src, a_src_b;
  logic [2:0] a_alu;
  logic [31:0] a_ret;
  logic       b_iord, b_mem_wr, b_ir_wr, b_pc_wr, b_src_a, b_reg_wr, b_addr, b_data, b_trap;
  logic [1:0] b_pc_src, b_src_b;
  logic [2:0] b_alu;
  logic [3:0] b_ret;

  multicycle_control_unit #(
    .OP_WIDTH_P(6), .FUNCT_WIDTH_P(6), .ALU_CNTRL_WIDTH_P(3),
    .CNT_WIDTH_P(32), .TRAP_EN_P(1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_function(funct),
    .i_zero(zero), .i_mem_ready(ready),
    .o_iord(a_iord), .o_mem_wr_en(a_mem_wr), .o_ir_wr_en(a_ir_wr),
    .o_pc_wr_en(a_pc_wr), .o_pc_src_sel(a_pc_src), .o_alu_src_a_sel(a_src_a),
    .o_alu_src_b_sel(a_src_b), .o_alu_cntrl(a_alu), .o_reg_wr_en(a_reg_wr),
    .o_reg_wr_addr_sel(a_addr), .o_reg_wr_data_sel(a_data), .o_trap(a_trap),
    .o_retired(a_ret)
  );

  multicycle_control_unit #(
    .OP_WIDTH_P(6), .FUNCT_WIDTH_P(6), .ALU_CNTRL_WIDTH_P(3),
    .CNT_WIDTH_P(4), .TRAP_EN_P(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_function(funct),
    .i_zero(zero), .i_mem_ready(ready),
    .o_iord(b_iord), .o_mem_wr_en(b_mem_wr), .o_ir_wr_en(b_ir_wr),
    .o_pc_wr_en(b_pc_wr), .o_pc_src_sel(b_pc_src), .o_alu_src_a_sel(b_src_a),
    .o_alu_src_b_sel(b_src_b), .o_alu_cntrl(b_alu), .o_reg_wr_en(b_reg_wr),
    .o_reg_wr_addr_sel(b_addr), .o_reg_wr_data_sel(b_data), .o_trap(b_trap),
    .o_retired(b_ret)
  );

  outs_t act_a, act_b;
  assign act_a = {a_iord, a_mem_wr, a_ir_wr, a_pc_wr, a_pc_src, a_src_a, a_src_b,
                  a_alu, a_reg_wr, a_addr, a_data, a_trap};
  assign act_b = {b_iord, b_mem_wr, b_ir_wr, b_pc_wr, b_pc_src, b_src_a, b_src_b,
                  b_alu, b_reg_wr, b_addr, b_data, b_trap};

  // Model state
  outs_t       exp_a, exp_b;
  bit          exp_rst;
  bit          chk_en = 1'b0;
  int unsigned cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_rst) begin
        chk("A_enables_in_reset", {28'd0, a_mem_wr, a_ir_wr, a_pc_wr, a_reg_wr}, 32'd0);
        chk("B_enables_in_reset", {28'd0, b_mem_wr, b_ir_wr, b_pc_wr, b_reg_wr}, 32'd0);
      end else begin
        chk("A_outputs", 32'(act_a), 32'(exp_a));
        chk("B_outputs", 32'(act_b), 32'(exp_b));
        chk("A_retired", a_ret, cnt);
        chk("B_retired", 32'(b_ret), cnt % 16);
      end
    end
  end

  // ---------------- expected-output builders per instruction step ----------
  function automatic outs_t base();
    outs_t o = '0;
    o.alu = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_fetch(input bit r);
    outs_t o = base(); o.src_b = 2'b01; o.ir_wr = r; o.pc_wr = r; return o;
  endfunction
  function automatic outs_t e_decode();
    outs_t o = base(); o.src_b = 2'b11; return o;
  endfunction
  function automatic outs_t e_addr_calc();
    outs_t o = base(); o.src_a = 1'b1; o.src_b = 2'b10; return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = base(); o.iord = 1'b1; return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = base(); o.reg_wr = 1'b1; o.data_sel = 1'b1; return o;
  endfunction
  function automatic outs_t e_memwrite();
    outs_t o = base(); o.iord = 1'b1; o.mem_wr = 1'b1; return o;
  endfunction
  function automatic outs_t e_exec(input logic [2:0] alu);
    outs_t o = base(); o.src_a = 1'b1; o.alu = alu; return o;
  endfunction
  function automatic outs_t e_aluwb();
    outs_t o = base(); o.reg_wr = 1'b1; o.addr_sel = 1'b1; return o;
  endfunction
  function automatic outs_t e_branch(input bit z);
    outs_t o = base(); o.src_a = 1'b1; o.alu = 3'b110; o.pc_src = 2'b01; o.pc_wr = z; return o;
  endfunction
  function automatic outs_t e_addiwb();
    outs_t o = base(); o.reg_wr = 1'b1; return o;
  endfunction
  function automatic outs_t e_jump();
    outs_t o = base(); o.pc_src = 2'b10; o.pc_wr = 1'b1; return o;
  endfunction
  function automatic outs_t e_trap();
    outs_t o = base(); o.trap = 1'b1; return o;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic [5:0] legal_fn(input int i);
    case (i)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  // kind: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J
  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      default: return 6'b000010;
    endcase
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction
  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // ---------------- stimulus ----------------------------------------------
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input bit rdy,
                     input bit z, input outs_t ea, input outs_t eb, input bit ret);
    rst_n = 1'b1; opcode = op; funct = fn; ready = rdy; zero = z;
    exp_a = ea; exp_b = eb; exp_rst = 1'b0;
    @(posedge clk);
    if (ret) cnt++;
    #1;
  endtask

  task automatic rst_cyc(input bit rdy);
    rst_n = 1'b0; opcode = r6(); funct = r6(); ready = rdy; zero = rb();
    exp_rst = 1'b1;
    @(posedge clk);
    cnt = 0;
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc(r6(), r6(), 1'b0, rb(), e_fetch(1'b0), e_fetch(1'b0), 1'b0);
    cyc(r6(), r6(), 1'b1, rb(), e_fetch(1'b1), e_fetch(1'b1), 1'b0);
  endtask

  task automatic run_instr(input int kind, input logic [5:0] fn, input bit z,
                           input int wf, input int wm);
    fetch(wf);
    cyc(op_of(kind), fn, rb(), rb(), e_decode(), e_decode(), 1'b0);
    case (kind)
      0: begin
        cyc(r6(), r6(), rb(), rb(), e_exec(alu_of(fn)), e_exec(alu_of(fn)), 1'b0);
        cyc(r6(), r6(), rb(), rb(), e_aluwb(), e_aluwb(), 1'b1);
      end
      1: begin
        cyc(r6(), r6(), rb(), rb(), e_addr_calc(), e_addr_calc(), 1'b0);
        for (int i = 0; i < wm; i++) cyc(r6(), r6(), 1'b0, rb(), e_memread(), e_memread(), 1'b0);
        cyc(r6(), r6(), 1'b1, rb(), e_memread(), e_memread(), 1'b0);
        cyc(r6(), r6(), rb(), rb(), e_memwb(), e_memwb(), 1'b1);
      end
      2: begin
        cyc(r6(), r6(), rb(), rb(), e_addr_calc(), e_addr_calc(), 1'b0);
        for (int i = 0; i < wm; i++) cyc(r6(), r6(), 1'b0, rb(), e_memwrite(), e_memwrite(), 1'b0);
        cyc(r6(), r6(), 1'b1, rb(), e_memwrite(), e_memwrite(), 1'b1);
      end
      3: cyc(r6(), r6(), rb(), z, e_branch(z), e_branch(z), 1'b1);
      4: begin
        cyc(r6(), r6(), rb(), rb(), e_addr_calc(), e_addr_calc(), 1'b0);
        cyc(r6(), r6(), rb(), rb(), e_addiwb(), e_addiwb(), 1'b1);
      end
      default: cyc(r6(), r6(), rb(), rb(), e_jump(), e_jump(), 1'b1);
    endcase
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; ready = 1'b0; zero = 1'b0;
    exp_a = base(); exp_b = base(); exp_rst = 1'b1;
    chk_en = 1'b1;
    rst_cyc(1'b1);
    rst_cyc(1'b0);
    #3;
    chk("reset_retired", a_ret, 32'd0);
    chk("reset_trap", {31'd0, a_trap}, 32'd0);

    // R-type subtract, zero waits
    run_instr(0, 6'b100010, 1'b0, 0, 0);
    chk("rtype_retired", a_ret, 32'd1);

    // LW with two wait cycles in MEMREAD
    run_instr(1, r6(), 1'b0, 0, 2);
    chk("lw_retired", a_ret, 32'd2);

    // Taken then not-taken branch
    run_instr(3, r6(), 1'b1, 0, 0);
    run_instr(3, r6(), 1'b0, 0, 0);
    chk("beq_retired", a_ret, 32'd4);

    // SW aborted by reset in MEMWRITE
    fetch(0);
    cyc(op_of(2), r6(), rb(), rb(), e_decode(), e_decode(), 1'b0);
    cyc(r6(), r6(), rb(), rb(), e_addr_calc(), e_addr_calc(), 1'b0);
    rst_cyc(1'b1);
    #3;
    chk("sw_abort_retired", a_ret, 32'd0);

    // Sixteen jumps wrap the 4-bit counter
    for (int i = 0; i < 16; i++) run_instr(5, r6(), 1'b0, 0, 0);
    #3;
    chk("j16_retired_b", 32'(b_ret), 32'd0);
    chk("j16_retired_a", a_ret, 32'd16);

    // Randomized legal instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      run_instr(kind, (kind == 0) ? legal_fn(int'($urandom_range(0, 4))) : r6(),
                rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Illegal opcode: A traps, B returns to FETCH (ready held low there)
    fetch(0);
    cyc(6'b111111, r6(), rb(), rb(), e_decode(), e_decode(), 1'b0);
    for (int i = 0; i < 11; i++) cyc(r6(), r6(), 1'b0, rb(), e_trap(), e_fetch(1'b0), 1'b0);
    #3;
    chk("trap_sticky", {31'd0, a_trap}, 32'd1);
    chk("nop_no_trap_b", {31'd0, b_trap}, 32'd0);

    rst_cyc(1'b0);
    #3;
    chk("trap_cleared", {31'd0, a_trap}, 32'd0);
    chk("retired_cleared", a_ret, 32'd0);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
